// File: rtl/sec_tick_gen_if.sv
// Bundle between the timebase and the traffic-light controller/board pins.
// Raw board inputs flow in, strobe/blink/run status flow out.
interface sec_tick_gen_if;
    logic key_pause_n;
    logic sw_fast;
    logic sec;
    logic blink;
    logic running;

    modport master (
        output key_pause_n,
        output sw_fast,
        input  sec,
        input  blink,
        input  running
    );

    modport slave (
        input  key_pause_n,
        input  sw_fast,
        output sec,
        output blink,
        output running
    );
endinterface

// File: rtl/sec_tick_gen.sv
// Timebase for the traffic-light controller: sec strobe, blink square wave,
// debounced run/pause toggle and fast demo rate select.
module sec_tick_gen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_DIV   = CLK_HZ,
    parameter int FAST_DIV   = CLK_HZ / 10,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst,
    sec_tick_gen_if.slave  bus
);

    localparam int MAX_DIV = (TICK_DIV > FAST_DIV) ? TICK_DIV : FAST_DIV;
    localparam int CW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
    localparam int SW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] TICK_HALF = CW'(TICK_DIV / 2 - 1);
    localparam logic [CW-1:0] FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [CW-1:0] FAST_HALF = CW'(FAST_DIV / 2 - 1);
    localparam logic [SW-1:0] DEB_LAST  = SW'(DEB_CYCLES - 1);

    logic          key_s1_q, key_s1_d;
    logic          key_s2_q, key_s2_d;
    logic          sw_s1_q, sw_s1_d;
    logic          sw_s2_q, sw_s2_d;
    logic          sw_prev_q, sw_prev_d;
    logic          key_deb_q, key_deb_d;
    logic [SW-1:0] stab_q, stab_d;
    logic          running_q, running_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sec_q, sec_d;
    logic          blink_q, blink_d;

    logic          press;
    logic          mode_chg;
    logic [CW-1:0] div_last;
    logic [CW-1:0] div_half;

    always_comb begin
        key_s1_d  = bus.key_pause_n;
        key_s2_d  = key_s1_q;
        sw_s1_d   = bus.sw_fast;
        sw_s2_d   = sw_s1_q;
        sw_prev_d = sw_s2_q;
        key_deb_d = key_deb_q;
        stab_d    = '0;
        running_d = running_q;
        cnt_d     = cnt_q;
        sec_d     = 1'b0;
        blink_d   = blink_q;
        press     = 1'b0;
        mode_chg  = (sw_s2_q != sw_prev_q);
        div_last  = sw_s2_q ? FAST_LAST : TICK_LAST;
        div_half  = sw_s2_q ? FAST_HALF : TICK_HALF;

        if (key_s2_q != key_deb_q) begin
            if (stab_q == DEB_LAST) begin
                key_deb_d = key_s2_q;
                press     = ~key_s2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end

        if (press) begin
            running_d = ~running_q;
        end

        // Prescaler decisions use the pre-toggle running value.
        if (mode_chg) begin
            cnt_d = '0;
        end else if (running_q) begin
            if (cnt_q == div_last) begin
                cnt_d   = '0;
                sec_d   = 1'b1;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == div_half) begin
                    blink_d = ~blink_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            key_s1_q  <= 1'b1;
            key_s2_q  <= 1'b1;
            sw_s1_q   <= 1'b0;
            sw_s2_q   <= 1'b0;
            sw_prev_q <= 1'b0;
            key_deb_q <= 1'b1;
            stab_q    <= '0;
            running_q <= 1'b1;
            cnt_q     <= '0;
            sec_q     <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            key_s1_q  <= key_s1_d;
            key_s2_q  <= key_s2_d;
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            sw_prev_q <= sw_prev_d;
            key_deb_q <= key_deb_d;
            stab_q    <= stab_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
            sec_q     <= sec_d;
            blink_q   <= blink_d;
        end
    end

    assign bus.sec     = sec_q;
    assign bus.blink   = blink_q;
    assign bus.running = running_q;

endmodule

// File: tb/tb_sec_tick_gen.sv
// Scoreboard bench for sec_tick_gen with small dividers.
// Expected sec cycles and blink/running snapshots are queued up front.
module tb_sec_tick_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int    cyc;
        logic  blink;
        logic  running;
        string tag;
    } snap_t;

    snap_t snap_q[$];
    int    sec_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sec_tick_gen_if bus ();

    sec_tick_gen #(
        .TICK_DIV   (10),
        .FAST_DIV   (4),
        .DEB_CYCLES (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        while (sec_q.size() > 0 && sec_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL sec_missing cyc=%0d actual sec=0 required sec=1",
                     sec_q[0]);
            void'(sec_q.pop_front());
        end
        if (cyc > 0 && bus.sec !== 1'b0) begin
            checks++;
            if (sec_q.size() > 0 && sec_q[0] == cyc) begin
                void'(sec_q.pop_front());
            end else begin
                failures++;
                $display("FAIL sec_unexpected cyc=%0d actual sec=%b required sec=0",
                         cyc, bus.sec);
            end
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            snap_t s;
            s = snap_q.pop_front();
            if (s.cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s_stale cyc=%0d actual=unchecked required=checked",
                         s.tag, s.cyc);
            end else begin
                checks++;
                if (bus.blink !== s.blink) begin
                    failures++;
                    $display("FAIL %s_blink cyc=%0d actual=%b required=%b",
                             s.tag, cyc, bus.blink, s.blink);
                end
                checks++;
                if (bus.running !== s.running) begin
                    failures++;
                    $display("FAIL %s_running cyc=%0d actual=%b required=%b",
                             s.tag, cyc, bus.running, s.running);
                end
            end
        end
    end

    task automatic exp_snap(input int c, input logic b, input logic r,
                            input string t);
        snap_t s;
        s.cyc = c;
        s.blink = b;
        s.running = r;
        s.tag = t;
        snap_q.push_back(s);
    endtask

    task automatic to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_snap(cyc + 1, 1'b0, 1'b1, "reset");
        to(cyc + 2);
        rst = 1'b1;
        base = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bus.key_pause_n = 1'b1;
        bus.sw_fast = 1'b0;

        // Free-running after reset
        do_reset();
        b = base;
        exp_snap(b + 4, 1'b0, 1'b1, "t1");
        exp_snap(b + 5, 1'b1, 1'b1, "t1");
        exp_snap(b + 9, 1'b1, 1'b1, "t1");
        exp_snap(b + 10, 1'b0, 1'b1, "t1");
        exp_snap(b + 14, 1'b0, 1'b1, "t1");
        exp_snap(b + 15, 1'b1, 1'b1, "t1");
        sec_q.push_back(b + 10);
        sec_q.push_back(b + 20);
        sec_q.push_back(b + 30);
        to(b + 32);

        // Pause then resume from held count
        do_reset();
        b = base;
        exp_snap(b + 15, 1'b1, 1'b1, "t2");
        exp_snap(b + 16, 1'b1, 1'b1, "t2");
        exp_snap(b + 17, 1'b1, 1'b0, "t2");
        exp_snap(b + 25, 1'b1, 1'b0, "t2");
        exp_snap(b + 33, 1'b1, 1'b0, "t2");
        exp_snap(b + 34, 1'b1, 1'b1, "t2");
        exp_snap(b + 36, 1'b1, 1'b1, "t2");
        exp_snap(b + 37, 1'b0, 1'b1, "t2");
        exp_snap(b + 41, 1'b0, 1'b1, "t2");
        exp_snap(b + 42, 1'b1, 1'b1, "t2");
        sec_q.push_back(b + 10);
        sec_q.push_back(b + 37);
        sec_q.push_back(b + 47);
        to(b + 12); bus.key_pause_n = 1'b0;
        to(b + 18); bus.key_pause_n = 1'b1;
        to(b + 29); bus.key_pause_n = 1'b0;
        to(b + 35); bus.key_pause_n = 1'b1;
        to(b + 50);

        // Bounces shorter than the debounce window
        do_reset();
        b = base;
        exp_snap(b + 12, 1'b0, 1'b1, "t3");
        exp_snap(b + 25, 1'b1, 1'b1, "t3");
        sec_q.push_back(b + 10);
        sec_q.push_back(b + 20);
        to(b + 2); bus.key_pause_n = 1'b0;
        to(b + 4); bus.key_pause_n = 1'b1;
        to(b + 5); bus.key_pause_n = 1'b0;
        to(b + 7); bus.key_pause_n = 1'b1;
        to(b + 27);

        // Switch to fast mode and back
        do_reset();
        b = base;
        exp_snap(b + 15, 1'b0, 1'b1, "t4");
        exp_snap(b + 16, 1'b0, 1'b1, "t4");
        exp_snap(b + 17, 1'b1, 1'b1, "t4");
        exp_snap(b + 18, 1'b1, 1'b1, "t4");
        exp_snap(b + 19, 1'b0, 1'b1, "t4");
        exp_snap(b + 21, 1'b1, 1'b1, "t4");
        sec_q.push_back(b + 10);
        sec_q.push_back(b + 19);
        sec_q.push_back(b + 23);
        sec_q.push_back(b + 27);
        sec_q.push_back(b + 31);
        to(b + 12); bus.sw_fast = 1'b1;
        to(b + 31); bus.sw_fast = 1'b0;
        to(b + 35);

        // Press accepted on the wrap edge
        do_reset();
        b = base;
        exp_snap(b + 9, 1'b1, 1'b1, "t5");
        exp_snap(b + 10, 1'b0, 1'b0, "t5");
        exp_snap(b + 20, 1'b0, 1'b0, "t5");
        exp_snap(b + 30, 1'b0, 1'b0, "t5");
        sec_q.push_back(b + 10);
        to(b + 5); bus.key_pause_n = 1'b0;
        to(b + 11); bus.key_pause_n = 1'b1;
        to(b + 32);

        // Reset while paused
        do_reset();
        b = base;
        exp_snap(b + 17, 1'b1, 1'b0, "t6");
        exp_snap(b + 20, 1'b1, 1'b0, "t6");
        sec_q.push_back(b + 10);
        to(b + 12); bus.key_pause_n = 1'b0;
        to(b + 18); bus.key_pause_n = 1'b1;
        to(b + 20);
        do_reset();
        b = base;
        exp_snap(b + 9, 1'b1, 1'b1, "t6r");
        exp_snap(b + 10, 1'b0, 1'b1, "t6r");
        sec_q.push_back(b + 10);
        sec_q.push_back(b + 20);
        to(b + 22);

        while (sec_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL sec_leftover cyc=%0d actual=unseen required=seen",
                     sec_q.pop_front());
        end
        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s_leftover cyc=%0d actual=unseen required=seen",
                     s.tag, s.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
